// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
//   - default parameter values
//   - rf_addr_w / rf_nlane helpers that derive address width and lane count
//   - rf_lane_merge: per-lane merge of a new word into an old word
// rf_lane_merge works on a fixed maximum width so one function serves every
// instance. Callers zero-pad their operands up to RF_MAX_W and keep the low
// bits of the result.
package rf_pkg;

  localparam int unsigned RF_DATA_W  = 32'd64;
  localparam int unsigned RF_DEPTH   = 32'd32;
  localparam int unsigned RF_LANE_W  = 32'd8;
  localparam int unsigned RF_NUM_RD  = 32'd2;
  localparam int unsigned RF_NUM_WR  = 32'd2;
  localparam int unsigned RF_R0_ZERO = 32'd1;

  // Widest word (and widest lane-enable vector) that rf_lane_merge can handle.
  localparam int unsigned RF_MAX_W   = 32'd256;
  localparam int unsigned RF_MAX_IW  = 32'd8;

  function automatic int unsigned rf_addr_w(input int unsigned depth);
    return (depth > 32'd1) ? int'($clog2(depth)) : 32'd1;
  endfunction

  function automatic int unsigned rf_nlane(input int unsigned data_w, input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  // Bit i of the result comes from new_w when its lane (i / lane_w) is enabled.
  function automatic logic [RF_MAX_W-1:0] rf_lane_merge(
    input logic [RF_MAX_W-1:0] old_w,
    input logic [RF_MAX_W-1:0] new_w,
    input logic [RF_MAX_W-1:0] be,
    input int unsigned         lane_w
  );
    logic [RF_MAX_W-1:0] merged;
    merged = old_w;
    for (int unsigned i = 0; i < RF_MAX_W; i++) begin
      if (be[RF_MAX_IW'(i / lane_w)]) begin
        merged[RF_MAX_IW'(i)] = new_w[RF_MAX_IW'(i)];
      end else begin
        merged[RF_MAX_IW'(i)] = old_w[RF_MAX_IW'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/rf_lane_bypass.sv
// Read-port bypass for register_file_mp.
// Starts from the stored word of rd_addr_i and overlays, lane by lane, every
// same-cycle write to that address in port order, so the highest port wins.
// Ports:
//   rd_addr_i  read address
//   wr_*_i     all write ports (enable, address, lane enables, data, clear)
//   stored_i   stored word at rd_addr_i
//   data_o     bypassed read word
//   clr_hit_o  some same-cycle write to rd_addr_i also clears its busy bit
module rf_lane_bypass
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = 32'd5,
  parameter int unsigned LANE_W  = RF_LANE_W,
  parameter int unsigned NUM_WR  = RF_NUM_WR,
  parameter int unsigned R0_ZERO = RF_R0_ZERO,
  localparam int unsigned NLANE  = rf_nlane(DATA_W, LANE_W)
) (
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*NLANE-1:0]  wr_be_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_WR-1:0]        wr_clr_i,
  input  logic [DATA_W-1:0]        stored_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     clr_hit_o
);

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NLANE-1:0]  be
  );
    logic [RF_MAX_W-1:0] o_pad;
    logic [RF_MAX_W-1:0] n_pad;
    logic [RF_MAX_W-1:0] b_pad;
    logic [RF_MAX_W-1:0] m_pad;
    o_pad = '0;
    n_pad = '0;
    b_pad = '0;
    o_pad[DATA_W-1:0] = old_w;
    n_pad[DATA_W-1:0] = new_w;
    b_pad[NLANE-1:0]  = be;
    m_pad = rf_lane_merge(o_pad, n_pad, b_pad, LANE_W);
    return m_pad[DATA_W-1:0];
  endfunction

  logic r0_blk_s;
  logic hit_s;

  // Register 0 is hard-wired when R0_ZERO is set: no write may bypass into it.
  assign r0_blk_s = (R0_ZERO != 32'd0) && (rd_addr_i == '0);

  // Overlay every hitting write in ascending port order.
  always_comb begin
    data_o    = stored_i;
    clr_hit_o = 1'b0;
    hit_s     = 1'b0;
    for (int p = 0; p < int'(NUM_WR); p++) begin
      hit_s     = wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == rd_addr_i) && !r0_blk_s;
      data_o    = merge_lanes(data_o, wr_data_i[p*DATA_W +: DATA_W],
                              hit_s ? wr_be_i[p*NLANE +: NLANE] : '0);
      clr_hit_o = clr_hit_o | (hit_s & wr_clr_i[p]);
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with per-lane write masks, write-to-read bypass and
// a per-register busy scoreboard used by decode to stall on RAW hazards.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   rd_addr_i     NUM_RD read addresses; rd_data_o / rd_busy_o are combinational
//   wr_en_i, wr_addr_i, wr_be_i, wr_data_i, wr_clr_i
//                 NUM_WR write ports, higher index wins; wr_clr_i also retires
//                 the busy bit of wr_addr_i
//   iss_en_i, iss_addr_i  mark a destination busy (new producer in flight)
//   busy_vec_o    registered scoreboard
module register_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned DEPTH   = RF_DEPTH,
  parameter int unsigned LANE_W  = RF_LANE_W,
  parameter int unsigned NUM_RD  = RF_NUM_RD,
  parameter int unsigned NUM_WR  = RF_NUM_WR,
  parameter int unsigned R0_ZERO = RF_R0_ZERO,
  localparam int unsigned ADDR_W = rf_addr_w(DEPTH),
  localparam int unsigned NLANE  = rf_nlane(DATA_W, LANE_W)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*NLANE-1:0]  wr_be_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_WR-1:0]        wr_clr_i,
  input  logic                     iss_en_i,
  input  logic [ADDR_W-1:0]        iss_addr_i,
  output logic [DEPTH-1:0]         busy_vec_o
);

  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NLANE-1:0]  be
  );
    logic [RF_MAX_W-1:0] o_pad;
    logic [RF_MAX_W-1:0] n_pad;
    logic [RF_MAX_W-1:0] b_pad;
    logic [RF_MAX_W-1:0] m_pad;
    o_pad = '0;
    n_pad = '0;
    b_pad = '0;
    o_pad[DATA_W-1:0] = old_w;
    n_pad[DATA_W-1:0] = new_w;
    b_pad[NLANE-1:0]  = be;
    m_pad = rf_lane_merge(o_pad, n_pad, b_pad, LANE_W);
    return m_pad[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  for (genvar r = 0; r < int'(DEPTH); r++) begin : g_reg
    if ((R0_ZERO != 32'd0) && (r == 0)) begin : g_zero
      assign regs_d[r] = '0;
      assign busy_d[r] = 1'b0;
    end else begin : g_live
      logic [DATA_W-1:0] word_s;
      logic              hit_s;
      logic              clr_s;
      logic              busy_s;

      // Merge each port's lanes in ascending order; issue beats a retiring clear.
      always_comb begin
        word_s = regs_q[r];
        clr_s  = 1'b0;
        hit_s  = 1'b0;
        for (int p = 0; p < int'(NUM_WR); p++) begin
          hit_s  = wr_en_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == ADDR_W'(r));
          word_s = merge_lanes(word_s, wr_data_i[p*DATA_W +: DATA_W],
                               hit_s ? wr_be_i[p*NLANE +: NLANE] : '0);
          clr_s  = clr_s | (hit_s & wr_clr_i[p]);
        end
        if (iss_en_i && (iss_addr_i == ADDR_W'(r))) begin
          busy_s = 1'b1;
        end else if (clr_s) begin
          busy_s = 1'b0;
        end else begin
          busy_s = busy_q[r];
        end
      end

      assign regs_d[r] = word_s;
      assign busy_d[r] = busy_s;
    end
  end

  // Storage and scoreboard state; reset forgets every in-flight producer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec_o = busy_q;

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    logic              clr_hit_s;
    logic              iss_hit_s;

    assign addr_s = rd_addr_i[p*ADDR_W +: ADDR_W];

    rf_lane_bypass #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .LANE_W  (LANE_W),
      .NUM_WR  (NUM_WR),
      .R0_ZERO (R0_ZERO)
    ) u_bypass (
      .rd_addr_i (addr_s),
      .wr_en_i   (wr_en_i),
      .wr_addr_i (wr_addr_i),
      .wr_be_i   (wr_be_i),
      .wr_data_i (wr_data_i),
      .wr_clr_i  (wr_clr_i),
      .stored_i  (regs_q[addr_s]),
      .data_o    (rd_data_o[p*DATA_W +: DATA_W]),
      .clr_hit_o (clr_hit_s)
    );

    // A retiring write hides the busy bit unless a new producer issues this cycle.
    assign iss_hit_s    = iss_en_i && (iss_addr_i == addr_s);
    assign rd_busy_o[p] = busy_q[addr_s] & ~(clr_hit_s & ~iss_hit_s);
  end

endmodule
